// File: rtl/apb2natv_bridge.sv
// apb2natv_bridge: APB slave to single-outstanding native request bridge with wait timeout and error counting
module apb2natv_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 apb_psel_i,
  input  logic                 apb_penable_i,
  input  logic                 apb_pwrite_i,
  input  logic [31:0]          apb_paddr_i,
  input  logic [31:0]          apb_pwdata_i,
  input  logic [3:0]           apb_pstrb_i,
  input  logic [2:0]           apb_pprot_i,
  output logic                 apb_pready_o,
  output logic [31:0]          apb_prdata_o,
  output logic                 apb_pslverr_o,
  output logic                 natv_valid_o,
  output logic [31:0]          natv_addr_o,
  output logic [31:0]          natv_wdata_o,
  output logic [3:0]           natv_wstrb_o,
  input  logic [31:0]          natv_rdata_i,
  input  logic                 natv_ready_i,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 2) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t               state_q, state_d;
  logic [31:0]          addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic                 write_q, write_d, err_q, err_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 timeout, done_err, unused_prot;
  assign unused_prot = ^apb_pprot_i;
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    write_d  = write_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    done_err = 1'b0;
    timeout  = (TIMEOUT_CYCLES != 0) && (int'(cnt_q) + 1 == TIMEOUT_CYCLES);
    case (state_q)
      IDLE: if (apb_psel_i) begin
        addr_d  = apb_paddr_i;
        wdata_d = apb_pwdata_i;
        wstrb_d = apb_pwrite_i ? apb_pstrb_i : 4'b0000;
        write_d = apb_pwrite_i;
        cnt_d   = '0;
        if (apb_paddr_i[1:0] == 2'b00) state_d = BUSY;
        else begin
          state_d  = DONE;
          err_d    = 1'b1;
          rdata_d  = '0;
          done_err = 1'b1;
        end
      end
      BUSY: if (natv_ready_i) begin
        state_d = DONE;
        rdata_d = write_q ? 32'h0 : natv_rdata_i;
        err_d   = 1'b0;
      end else if (timeout) begin
        state_d  = DONE;
        rdata_d  = '0;
        err_d    = 1'b1;
        done_err = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      // A waiting master completes on psel&penable; a master that left discards the response
      DONE: if (!apb_psel_i || apb_penable_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    err_cnt_d = (done_err && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign apb_pready_o  = (state_q == DONE) && apb_psel_i && apb_penable_i;
  assign apb_prdata_o  = apb_pready_o ? rdata_q : 32'h0;
  assign apb_pslverr_o = apb_pready_o && err_q;
  assign natv_valid_o  = (state_q == BUSY);
  assign natv_addr_o   = addr_q;
  assign natv_wdata_o  = wdata_q;
  assign natv_wstrb_o  = wstrb_q;
  assign err_cnt_o     = err_cnt_q;
endmodule

// File: tb/tb_apb2natv_bridge.sv
// tb_apb2natv_bridge: randomized APB transfers against a transfer-level reference model
module tb_apb2natv_bridge;
  localparam int TO = 4;
  localparam int EW = 2;
  logic          clk = 1'b0, rst;
  logic          psel, penable, pwrite, pready, pslverr, natv_valid, natv_ready;
  logic [31:0]   paddr, pwdata, prdata, natv_addr, natv_wdata, natv_rdata;
  logic [3:0]    pstrb, natv_wstrb;
  logic [2:0]    pprot;
  logic [EW-1:0] err_cnt;
  int            n_tests = 0, n_fail = 0, exp_err = 0;
  always #5 clk = ~clk;
  apb2natv_bridge #(.TIMEOUT_CYCLES(TO), .ERR_CNT_W(EW)) dut (
    .clk_i(clk), .rst_i(rst),
    .apb_psel_i(psel), .apb_penable_i(penable), .apb_pwrite_i(pwrite),
    .apb_paddr_i(paddr), .apb_pwdata_i(pwdata), .apb_pstrb_i(pstrb), .apb_pprot_i(pprot),
    .apb_pready_o(pready), .apb_prdata_o(prdata), .apb_pslverr_o(pslverr),
    .natv_valid_o(natv_valid), .natv_addr_o(natv_addr), .natv_wdata_o(natv_wdata),
    .natv_wstrb_o(natv_wstrb), .natv_rdata_i(natv_rdata), .natv_ready_i(natv_ready),
    .err_cnt_o(err_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_pready"}, {31'h0, pready}, 0);
    chk({tag, "_prdata"}, prdata, 0);
    chk({tag, "_pslverr"}, {31'h0, pslverr}, 0);
    chk({tag, "_valid"}, {31'h0, natv_valid}, 0);
    chk({tag, "_addr"}, natv_addr, 0);
    chk({tag, "_wdata"}, natv_wdata, 0);
    chk({tag, "_wstrb"}, {28'h0, natv_wstrb}, 0);
    chk({tag, "_errcnt"}, {{(32-EW){1'b0}}, err_cnt}, 0);
  endtask
  // One APB transfer; native side answers on valid cycle k (0-based), never if k >= TO
  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                      input logic [3:0] s, input logic w, input int k, input bit drop);
    logic [3:0] es = w ? s : 4'b0000;
    bit mis = (a[1:0] != 2'b00);
    bit tmo = !mis && (k >= TO);
    bit err = mis || tmo;
    int lat = mis ? 1 : (tmo ? TO + 1 : k + 2);
    int vexp = mis ? 0 : (tmo ? TO : k + 1);
    logic [31:0] erd = (err || w) ? 32'h0 : rd;
    int vcnt = 0, pcyc = -1;
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = wd; pstrb = s; pprot = 3'($urandom); natv_ready = 0;
    @(negedge clk);
    chk("setup_pready", {31'h0, pready}, 0);
    for (int c = 1; c <= lat + 2 && pcyc < 0; c++) begin
      @(posedge clk); #1;
      psel = !drop; penable = 1; natv_ready = 0;
      paddr = $urandom; pwdata = $urandom; pstrb = 4'($urandom); pwrite = 1'($urandom);
      @(negedge clk);
      if (natv_valid) begin
        chk("natv_addr", natv_addr, a);
        chk("natv_wdata", natv_wdata, wd);
        chk("natv_wstrb", {28'h0, natv_wstrb}, {28'h0, es});
        natv_ready = (vcnt == k);
        natv_rdata = natv_ready ? rd : $urandom;
        vcnt++;
      end
      if (pready) begin
        pcyc = c;
        chk("prdata", prdata, erd);
        chk("pslverr", {31'h0, pslverr}, {31'h0, err});
      end else begin
        chk("prdata_idle", prdata, 0);
        chk("pslverr_idle", {31'h0, pslverr}, 0);
      end
    end
    if (err) exp_err = (exp_err + 1 > 3) ? 3 : exp_err + 1;
    chk("valid_cycles", vcnt, vexp);
    chk("pready_cycle", pcyc, drop ? -1 : lat);
    @(posedge clk); #1;
    psel = 0; penable = 0; natv_ready = 0;
    @(negedge clk);
    chk("after_valid", {31'h0, natv_valid}, 0);
    chk("after_pready", {31'h0, pready}, 0);
    chk("err_cnt", {{(32-EW){1'b0}}, err_cnt}, exp_err);
  endtask
  initial begin
    rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0; pprot = 0;
    natv_ready = 0; natv_rdata = 0;
    #12;
    chk_idle_outputs("reset");
    @(negedge clk); rst = 0;
    xfer(32'h0300_0004, 32'hDEAD_BEEF, 32'h0, 4'b0011, 1, 3, 0);
    xfer(32'h0300_0010, 32'h0, 32'h1234_5678, 4'b1111, 0, 0, 0);
    xfer(32'h0300_0020, 32'h0, 32'hCAFE_0000, 4'b0000, 0, 99, 0);
    xfer(32'h0300_0002, 32'h5555_AAAA, 32'h0, 4'b1111, 1, 0, 0);
    xfer(32'h0300_0030, 32'h0BAD_F00D, 32'h7777_7777, 4'b0000, 1, 1, 0);
    xfer(32'h0300_0040, 32'h0, 32'h0, 4'b0000, 0, TO, 0);
    for (int i = 0; i < 4; i++) xfer(32'h0300_0100 + 32'(i * 4), 32'h0, 32'h0, 4'b0000, 0, 50, 0);
    xfer(32'h0300_0050, 32'h1111_2222, 32'h0, 4'b1000, 1, 2, 1);
    xfer(32'h0300_0054, 32'h0, 32'h3333_4444, 4'b0000, 0, 1, 0);
    // Reset during BUSY, with a new setup waiting on the first edge after release
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h0300_0060;
    @(posedge clk); #1;
    penable = 1;
    @(negedge clk);
    chk("busy_before_rst", {31'h0, natv_valid}, 1);
    rst = 1; #1;
    chk_idle_outputs("rst_busy");
    exp_err = 0;
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h0300_0070; pwdata = 32'hA5A5_5A5A; pstrb = 4'b0101;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    penable = 1;
    @(negedge clk);
    chk("post_rst_valid", {31'h0, natv_valid}, 1);
    chk("post_rst_addr", natv_addr, 32'h0300_0070);
    chk("post_rst_wstrb", {28'h0, natv_wstrb}, 32'h5);
    natv_ready = 1;
    @(posedge clk); #1;
    natv_ready = 0;
    @(negedge clk);
    chk("post_rst_pready", {31'h0, pready}, 1);
    chk("post_rst_pslverr", {31'h0, pslverr}, 0);
    @(posedge clk); #1;
    psel = 0; penable = 0;
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a = {$urandom} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      xfer(a, $urandom, $urandom, 4'($urandom), 1'($urandom), int'($urandom_range(0, 6)),
           $urandom_range(0, 7) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apb2natv_bridge.md
APB2NATV_BRIDGE -- requirements
Module: apb2natv_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: native wait-cycle limit; 0 disables timeout.
REQ-002 SHALL have parameter ERR_CNT_W, default 8: width of the error counter.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 apb_psel_i  input  1  APB select.
REQ-007 apb_penable_i  input  1  APB access phase.
REQ-008 apb_pwrite_i  input  1  1 = write.
REQ-009 apb_paddr_i  input  32  byte address.
REQ-010 apb_pwdata_i  input  32  write data.
REQ-011 apb_pstrb_i  input  4  write byte strobes.
REQ-012 apb_pprot_i  input  3  accepted, ignored.
REQ-013 apb_pready_o  output  1  transfer complete.
REQ-014 apb_prdata_o  output  32  read data.
REQ-015 apb_pslverr_o  output  1  transfer error.
REQ-016 natv_valid_o  output  1  native request valid.
REQ-017 natv_addr_o  output  32  native address.
REQ-018 natv_wdata_o  output  32  native write data.
REQ-019 natv_wstrb_o  output  4  strobes; 4'b0000 = read.
REQ-020 natv_rdata_i  input  32  native read data, valid with ready.
REQ-021 natv_ready_i  input  1  native completion.
REQ-022 err_cnt_o  output  ERR_CNT_W  saturating count of errored transfers.

Function
REQ-023 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-024 In IDLE, when apb_psel_i=1, SHALL latch paddr, pwdata and wstrb, where wstrb = pwrite ? pstrb : 4'b0000 and pwrite=1 with pstrb=0 is sent as 4'b0000.
- Triggers with or without penable.
REQ-025 IDLE, aligned address (paddr[1:0]=0): -> BUSY, natv_valid_o=1 from the next cycle.
REQ-026 IDLE, misaligned address: -> DONE with error set; no native request issued.
REQ-027 In BUSY, natv_valid_o, natv_addr_o, natv_wdata_o and natv_wstrb_o SHALL stay stable until natv_ready_i=1 is sampled.
REQ-028 BUSY, natv_ready_i=1: capture natv_rdata_i for reads (0 for writes), clear error, natv_valid_o=0 next cycle, -> DONE.
REQ-029 BUSY wait counter: starts at 0 on BUSY entry, increments each BUSY cycle without ready.
- Counter reaching TIMEOUT_CYCLES (parameter non-zero): natv_valid_o=0, prdata captured 0, error set, -> DONE.
- natv_ready_i=1 in the same cycle takes priority over timeout.
REQ-030 DONE, apb_psel_i=1 and apb_penable_i=1: apb_pready_o=1 for exactly that one cycle, prdata/pslverr driven from captured values, -> IDLE.
- apb_pready_o SHALL be 0 in every other state and cycle.
REQ-031 DONE, apb_psel_i=0: the response SHALL be discarded and the FSM returns to IDLE with pready=0.
REQ-032 apb_psel_i dropping during BUSY SHALL NOT cancel the native request; the request completes normally (REQ-028/029).
REQ-033 apb_prdata_o SHALL be 0 whenever apb_pready_o=0.
REQ-034 apb_pslverr_o SHALL be 0 whenever apb_pready_o=0.
REQ-035 Minimum latency: setup at cycle T, natv_valid_o at T+1; ready at T+1+k gives apb_pready_o at T+2+k (k>=0).
REQ-036 err_cnt_o SHALL increment by 1 on each entry to DONE with error set and saturate at all-ones without wrapping.
REQ-037 At most one native request SHALL be outstanding at any time; natv_valid_o SHALL never be asserted outside BUSY.

Reset
REQ-038 rst_i=1 SHALL, asynchronously and regardless of state, force the FSM to IDLE.
REQ-039 rst_i=1 SHALL force to 0: natv_valid_o, natv_addr_o, natv_wdata_o, natv_wstrb_o, apb_pready_o, apb_prdata_o, apb_pslverr_o, err_cnt_o and the wait counter.
REQ-040 Reset during BUSY SHALL drop natv_valid_o immediately; the interrupted transfer is lost and no APB response is produced.
REQ-041 After rst_i deasserts, the first rising edge SHALL accept a new APB setup.

Verification
REQ-042 Write: paddr=0x0300_0004, pwdata=0xDEAD_BEEF, pstrb=4'b0011, ready after 3 cycles -> natv_wstrb_o=4'b0011 held for 4 valid cycles; pready=1, pslverr=0 one cycle after ready.
REQ-043 Read: paddr=0x0300_0010, ready same cycle as valid with rdata=0x1234_5678 -> prdata=0x1234_5678 at T+2, natv_wstrb_o=0.
REQ-044 Timeout: TIMEOUT_CYCLES=4, ready held 0 -> valid drops after 4 cycles, pready=1, pslverr=1, prdata=0, err_cnt_o=1.
REQ-045 Misaligned: paddr=0x0300_0002 -> natv_valid_o never asserts; pready=1, pslverr=1 at T+1 (penable high); err_cnt_o=1.
REQ-046 Saturation/abort: ERR_CNT_W=2, 5 timeouts -> err_cnt_o=3.
- psel dropped in BUSY -> native request still completes, no pready.
- rst_i pulsed mid-BUSY -> all outputs 0 immediately.
